// File: rtl/pedestrian_signal.sv
// Pedestrian WALK / DONT-WALK controller slaved to the vehicle lamp outputs.
// Grants WALK inside a vehicle-red phase and latches a sticky illegal-lamp fault.
module pedestrian_signal #(
    parameter int WALK_SECS  = 80,
    parameter int FLASH_SECS = 12,
    parameter int AUTO_WALK  = 0,
    parameter int CNT_W      = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             M,
    input  logic             K,
    input  logic             H,
    input  logic             btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_FLASH = 2'd2;
    localparam logic [1:0] ST_DARK  = 2'd3;

    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WALK_SECS + FLASH_SECS);
    localparam logic [CNT_W-1:0] FLS   = CNT_W'(FLASH_SECS);
    localparam logic [CNT_W-1:0] FLS1  = CNT_W'(FLASH_SECS + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic             AUTO  = (AUTO_WALK != 0);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic             req_n, fault_n, fph, fph_n;
    logic             red_q, walk_n, dw_n;
    logic             red, dark, illegal, red_rise;
    logic [1:0]       nlit;

    assign nlit     = {1'b0, M} + {1'b0, K} + {1'b0, H};
    assign red      = M & ~K & ~H;
    assign dark     = ~M & ~K & ~H;
    assign illegal  = nlit > 2'd1;
    assign red_rise = red & ~red_q;

    always_comb begin
        state_n = state;
        cnt_n   = countdown;
        req_n   = req_pending;
        fault_n = fault;
        fph_n   = fph;
        if (illegal) begin
            fault_n = 1'b1;
            state_n = ST_STOP;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (!fault && red_rise && (req_pending || btn || AUTO)) begin
                        state_n = ST_WALK;
                        cnt_n   = TOTAL;
                        req_n   = 1'b0;
                    end else if (!fault && dark) begin
                        state_n = ST_DARK;
                    end else if (btn && !dark) begin
                        req_n = 1'b1;
                    end
                end
                ST_WALK: begin
                    if (!red) begin
                        state_n = ST_STOP;
                        cnt_n   = '0;
                    end else if (tick) begin
                        if (countdown == FLS1) begin
                            cnt_n   = FLS;
                            fph_n   = 1'b1;
                            state_n = ST_FLASH;
                        end else if (countdown != '0) begin
                            cnt_n = countdown - ONE;
                        end
                    end
                end
                ST_FLASH: begin
                    if (!red) begin
                        state_n = ST_STOP;
                        cnt_n   = '0;
                    end else if (tick) begin
                        fph_n = ~fph;
                        if (countdown <= ONE) begin
                            cnt_n   = '0;
                            state_n = ST_STOP;
                        end else begin
                            cnt_n = countdown - ONE;
                        end
                    end
                end
                default: begin
                    cnt_n = '0;
                    if (!dark) state_n = ST_STOP;
                end
            endcase
        end
    end

    // Lamp outputs are decoded from the next state so they stay registered.
    always_comb begin
        walk_n = (state_n == ST_WALK);
        dw_n   = 1'b0;
        if (state_n == ST_STOP)  dw_n = 1'b1;
        if (state_n == ST_FLASH) dw_n = fph_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_STOP;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= '0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
            fph         <= 1'b0;
            red_q       <= 1'b1;
        end else begin
            state       <= state_n;
            walk        <= walk_n;
            dont_walk   <= dw_n;
            countdown   <= cnt_n;
            req_pending <= req_n;
            fault       <= fault_n;
            fph         <= fph_n;
            red_q       <= red;
        end
    end

endmodule
